snl_turn_controller: RTL and testbench
======================================

Name: snl_turn_controller

Overview:
- Turn sequencer for the Snakes-and-Ladders game. It owns the dice roller output, shares it between up to four players in round-robin order, and adds the latched dice value to the current player's square.
- After the move it queries the external board ROM for snake/ladder destinations, commits the final square and detects the winner.
- It sits between the key-debounce logic and the dice generator on one side, and the board ROM and display/VGA logic on the other.

Parameters:
- NUM_PLAYERS, 2, active players (1..4); player IDs 0..NUM_PLAYERS-1.
- BOARD_MAX, 100, final square (legal range 2..127).
- EXACT_FINISH, 1, 1 = a move overshooting BOARD_MAX is discarded; 0 = the move clamps to BOARD_MAX.
- SIX_REPEAT, 1, 1 = rolling a 6 grants the same player another turn.

Ports:
- clock, input, 1, system clock (50 MHz).
- reset, input, 1, asynchronous active-high reset.
- roll_req, input, 1, synchronised active-high roll key level.
- dice_value, input, 4, current dice generator output.
- sq_dest, input, 7, board ROM destination for sq_query (combinational, same cycle).
- sq_query, output, 7, square presented to the board ROM.
- cur_player, output, 2, player whose turn it is.
- positions, output, 28, square of player i on bits [7i+6:7i].
- dice_latched, output, 4, dice value used for the last accepted roll.
- busy, output, 1, high while not in IDLE or WIN.
- turn_done, output, 1, one-cycle pulse after a commit.
- invalid_roll, output, 1, one-cycle pulse when a roll is rejected.
- winner_valid, output, 1, high once a player reaches BOARD_MAX.
- winner_id, output, 2, winning player.

Behaviour:
- Reset (async, any state, including mid-turn):
  - state=IDLE, every position=1, cur_player=0, dice_latched=0.
  - All pulses=0, winner_valid=0, winner_id=0, sq_query=0, roll edge register=0.
- Roll detection:
  - Rising edge of roll_req (sampled 0 at the previous edge, 1 at this edge), honoured only in IDLE.
  - Edges arriving in any other state are dropped.
  - A held-high roll_req never re-triggers a roll.
- States: IDLE, MOVE, LOOKUP, COMMIT, WIN.
- IDLE, edge k with a roll:
  - If dice_value is in 1..6: dice_latched<=dice_value, go to MOVE.
  - Otherwise (0 or >=7): stay in IDLE; invalid_roll=1 for the cycle after edge k; dice_latched unchanged.
- MOVE, edge k+1: target<=pos[cur]+dice_latched, computed at 8-bit width (no wrap).
  - If target>BOARD_MAX: EXACT_FINISH=1 gives target<=pos[cur]; EXACT_FINISH=0 gives target<=BOARD_MAX.
  - Go to LOOKUP.
- LOOKUP: sq_query=target[6:0] for the whole state (registered, not 0).
  - Edge k+2: final<=sq_dest if 1<=sq_dest<=BOARD_MAX, else final<=target.
  - Go to COMMIT.
- COMMIT, edge k+3:
  - pos[cur]<=final; turn_done=1 for exactly the cycle after edge k+3.
  - If final==BOARD_MAX: winner_valid<=1, winner_id<=cur, go to WIN (cur_player unchanged).
  - Else if SIX_REPEAT and dice_latched==6: cur unchanged, go to IDLE.
  - Else cur<=(cur==NUM_PLAYERS-1)?0:cur+1, go to IDLE.
- Roll-to-commit latency: 3 clocks; updated positions and cur_player are visible together with turn_done.
- WIN: all rolls ignored, no pulses, outputs frozen until reset.
- Unused player slots (i>=NUM_PLAYERS) stay at 1.
- sq_query holds its last value outside LOOKUP.

Test Plan:
- Reset, wait 5 clocks -> positions all 1, cur_player=0, busy=0, winner_valid=0; then roll with dice_value=3 -> after 3 clocks pos0=4, turn_done one cycle, cur_player=1, sq_query was 4 during LOOKUP.
- ROM maps 4->14 and P0 is on 1 with dice=3 -> pos0=14; ROM maps 17->7 and P1 is on 12 with dice=5 -> pos1=7; ROM returns 0 -> target kept.
- P0 on 98 with dice=4: EXACT_FINISH=1 -> pos0=98, turn passes; EXACT_FINISH=0 -> pos0=100, winner_valid=1, winner_id=0, and later rolls are ignored.
- dice=6 with SIX_REPEAT=1 -> cur_player stays 0; next roll 2 -> cur_player advances; NUM_PLAYERS=3 -> player order wraps 2->0.
- dice_value=0 and then 7 on a roll edge -> invalid_roll pulse each time, no state change; roll_req held high for 20 clocks -> exactly one turn; second edge during MOVE -> ignored.
- reset asserted during LOOKUP -> immediate IDLE, positions 1, no turn_done pulse.

Source files
------------

// File: rtl/snl_turn_controller_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : snl_turn_controller_if
// Purpose  : Bundles the roll/dice inputs, the board-ROM query pair and the
//            game-state outputs of the Snakes-and-Ladders turn controller.
// Revision : 1.0  initial release
// ---------------------------------------------------------------------------
interface snl_turn_controller_if;
  // Environment -> controller
  logic        roll_req;
  logic [3:0]  dice_value;
  logic [6:0]  sq_dest;
  // Controller -> environment
  logic [6:0]  sq_query;
  logic [1:0]  cur_player;
  logic [27:0] positions;
  logic [3:0]  dice_latched;
  logic        busy;
  logic        turn_done;
  logic        invalid_roll;
  logic        winner_valid;
  logic [1:0]  winner_id;

  // Environment side: keys, dice generator, board ROM, display
  modport master (
    output roll_req, dice_value, sq_dest,
    input  sq_query, cur_player, positions, dice_latched,
    input  busy, turn_done, invalid_roll, winner_valid, winner_id
  );

  // Controller side
  modport slave (
    input  roll_req, dice_value, sq_dest,
    output sq_query, cur_player, positions, dice_latched,
    output busy, turn_done, invalid_roll, winner_valid, winner_id
  );
endinterface
`default_nettype wire

// File: rtl/snl_turn_controller.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : snl_turn_controller
// Purpose  : Round-robin turn sequencer: latches a dice roll, advances the
//            current player, resolves snakes/ladders via the board ROM,
//            commits the square and flags the winner.
// Revision : 1.0  initial release
// ---------------------------------------------------------------------------
module snl_turn_controller #(
  parameter int NUM_PLAYERS  = 2,
  parameter int BOARD_MAX    = 100,
  parameter int EXACT_FINISH = 1,
  parameter int SIX_REPEAT   = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  snl_turn_controller_if.slave bus
);

  localparam logic [7:0] C_BMAX8  = 8'(BOARD_MAX);
  localparam logic [6:0] C_BMAX7  = 7'(BOARD_MAX);
  localparam logic [1:0] C_LAST_P = 2'(NUM_PLAYERS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_MOVE   = 3'd1,
    S_LOOKUP = 3'd2,
    S_COMMIT = 3'd3,
    S_WIN    = 3'd4
  } state_t;

  state_t      state_q;
  logic        roll_q;
  logic [6:0]  pos_q [0:3];
  logic [1:0]  cur_q;
  logic [3:0]  dl_q;
  logic [6:0]  sq_q;      // doubles as the move target once MOVE completes
  logic [6:0]  fin_q;
  logic        td_q;
  logic        inv_q;
  logic        winv_q;
  logic [1:0]  wid_q;

  logic [7:0]  sum_d;
  logic [6:0]  tgt_d;
  logic [6:0]  fin_d;
  logic        edge_d;
  logic        dice_ok_d;

  // Move arithmetic, ROM destination validation and roll-edge qualification
  always_comb begin
    sum_d     = {1'b0, pos_q[cur_q]} + {4'd0, dl_q};
    tgt_d     = sum_d[6:0];
    if (sum_d > C_BMAX8) begin
      tgt_d = (EXACT_FINISH != 0) ? pos_q[cur_q] : C_BMAX7;
    end
    fin_d     = ((bus.sq_dest != 7'd0) && (bus.sq_dest <= C_BMAX7)) ? bus.sq_dest : sq_q;
    edge_d    = bus.roll_req & ~roll_q;
    dice_ok_d = (bus.dice_value >= 4'd1) && (bus.dice_value <= 4'd6);
  end

  // Turn state machine with registered outputs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      roll_q  <= 1'b0;
      for (int i = 0; i < 4; i++) pos_q[i] <= 7'd1;
      cur_q   <= 2'd0;
      dl_q    <= 4'd0;
      sq_q    <= 7'd0;
      fin_q   <= 7'd0;
      td_q    <= 1'b0;
      inv_q   <= 1'b0;
      winv_q  <= 1'b0;
      wid_q   <= 2'd0;
    end else begin
      roll_q <= bus.roll_req;
      td_q   <= 1'b0;
      inv_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (edge_d) begin
            if (dice_ok_d) begin
              dl_q    <= bus.dice_value;
              state_q <= S_MOVE;
            end else begin
              inv_q <= 1'b1;
            end
          end
        end
        S_MOVE: begin
          sq_q    <= tgt_d;
          state_q <= S_LOOKUP;
        end
        S_LOOKUP: begin
          fin_q   <= fin_d;
          state_q <= S_COMMIT;
        end
        S_COMMIT: begin
          pos_q[cur_q] <= fin_q;
          td_q         <= 1'b1;
          if (fin_q == C_BMAX7) begin
            winv_q  <= 1'b1;
            wid_q   <= cur_q;
            state_q <= S_WIN;
          end else begin
            // A six keeps the turn with the same player when enabled
            if (!((SIX_REPEAT != 0) && (dl_q == 4'd6))) begin
              cur_q <= (cur_q == C_LAST_P) ? 2'd0 : cur_q + 2'd1;
            end
            state_q <= S_IDLE;
          end
        end
        S_WIN: begin
          state_q <= S_WIN;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.sq_query     = sq_q;
  assign bus.cur_player   = cur_q;
  assign bus.positions    = {pos_q[3], pos_q[2], pos_q[1], pos_q[0]};
  assign bus.dice_latched = dl_q;
  assign bus.busy         = (state_q != S_IDLE) && (state_q != S_WIN);
  assign bus.turn_done    = td_q;
  assign bus.invalid_roll = inv_q;
  assign bus.winner_valid = winv_q;
  assign bus.winner_id    = wid_q;

endmodule
`default_nettype wire

// File: tb/tb_snl_turn_controller.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : tb_snl_turn_controller
// Purpose  : Drives three controller configurations with shared roll/dice
//            stimulus and a table-driven board ROM, comparing every cycle
//            against a turn-level game model plus literal spot checks.
// Revision : 1.0  initial release
// ---------------------------------------------------------------------------
module tb_snl_turn_controller;

  localparam int C_BM = 100;

  logic       clk = 1'b0;
  logic       rst;
  logic       roll_r;
  logic [3:0] dice_r;
  logic [6:0] rom_tab [0:127];
  logic       inv_seen;

  int total = 0;
  int bad   = 0;

  // Per-instance configuration: u0 exact finish, u1 clamping, u2 three players
  int cfg_np [3] = '{2, 2, 3};
  int cfg_ef [3] = '{1, 0, 1};

  snl_turn_controller_if if0 ();
  snl_turn_controller_if if1 ();
  snl_turn_controller_if if2 ();

  assign if0.roll_req = roll_r;  assign if0.dice_value = dice_r;  assign if0.sq_dest = rom_tab[if0.sq_query];
  assign if1.roll_req = roll_r;  assign if1.dice_value = dice_r;  assign if1.sq_dest = rom_tab[if1.sq_query];
  assign if2.roll_req = roll_r;  assign if2.dice_value = dice_r;  assign if2.sq_dest = rom_tab[if2.sq_query];

  snl_turn_controller #(.NUM_PLAYERS(2), .BOARD_MAX(C_BM), .EXACT_FINISH(1), .SIX_REPEAT(1))
    u_dut0 (.clock(clk), .reset(rst), .bus(if0));
  snl_turn_controller #(.NUM_PLAYERS(2), .BOARD_MAX(C_BM), .EXACT_FINISH(0), .SIX_REPEAT(1))
    u_dut1 (.clock(clk), .reset(rst), .bus(if1));
  snl_turn_controller #(.NUM_PLAYERS(3), .BOARD_MAX(C_BM), .EXACT_FINISH(1), .SIX_REPEAT(1))
    u_dut2 (.clock(clk), .reset(rst), .bus(if2));

  always #5 clk = ~clk;

  // ---------------- game model ----------------
  int m_pos [3][4];
  int m_cur [3], m_dl [3], m_sq [3], m_wid [3];
  int m_cnt [3], m_tgt [3], m_fin [3];
  bit m_td [3], m_inv [3], m_win [3], m_prev [3];

  task automatic model_reset(input int u);
    for (int p = 0; p < 4; p++) m_pos[u][p] = 1;
    m_cur[u] = 0; m_dl[u] = 0; m_sq[u] = 0; m_wid[u] = 0;
    m_cnt[u] = 0; m_tgt[u] = 0; m_fin[u] = 0;
    m_td[u] = 0; m_inv[u] = 0; m_win[u] = 0; m_prev[u] = 0;
  endtask

  // One clock of the game: a roll resolves fully at acceptance, then its
  // query and result appear after fixed delays of 1 and 3 clocks.
  task automatic model_step(input int u);
    bit edge_seen;
    int sum, d;
    edge_seen = roll_r && !m_prev[u];
    m_prev[u] = roll_r;
    m_td[u] = 0;
    m_inv[u] = 0;
    if (m_win[u]) begin
      // game over, nothing moves
    end else if (m_cnt[u] == 0) begin
      if (edge_seen) begin
        if (dice_r >= 1 && dice_r <= 6) begin
          m_dl[u] = int'(dice_r);
          sum = m_pos[u][m_cur[u]] + m_dl[u];
          if (sum > C_BM) m_tgt[u] = cfg_ef[u] ? m_pos[u][m_cur[u]] : C_BM;
          else            m_tgt[u] = sum;
          d = int'(rom_tab[m_tgt[u]]);
          m_fin[u] = (d >= 1 && d <= C_BM) ? d : m_tgt[u];
          m_cnt[u] = 3;
        end else begin
          m_inv[u] = 1;
        end
      end
    end else begin
      m_cnt[u]--;
      if (m_cnt[u] == 2) m_sq[u] = m_tgt[u];
      if (m_cnt[u] == 0) begin
        m_pos[u][m_cur[u]] = m_fin[u];
        m_td[u] = 1;
        if (m_fin[u] == C_BM) begin
          m_win[u] = 1;
          m_wid[u] = m_cur[u];
        end else if (m_dl[u] != 6) begin
          m_cur[u] = (m_cur[u] + 1) % cfg_np[u];
        end
      end
    end
  endtask

  // Advance the model alongside the DUTs
  always @(posedge clk or posedge rst) begin
    for (int u = 0; u < 3; u++) begin
      if (rst) model_reset(u);
      else     model_step(u);
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cmp(input int u, input logic [27:0] pos, input logic [1:0] cur,
                     input logic [3:0] dl, input logic [6:0] sq, input logic bsy,
                     input logic td, input logic inv, input logic wv, input logic [1:0] wid);
    logic [27:0] ep;
    ep = {7'(m_pos[u][3]), 7'(m_pos[u][2]), 7'(m_pos[u][1]), 7'(m_pos[u][0])};
    chk($sformatf("u%0d.positions", u),    32'(pos), 32'(ep));
    chk($sformatf("u%0d.cur_player", u),   32'(cur), 32'(m_cur[u]));
    chk($sformatf("u%0d.dice_latched", u), 32'(dl),  32'(m_dl[u]));
    chk($sformatf("u%0d.sq_query", u),     32'(sq),  32'(m_sq[u]));
    chk($sformatf("u%0d.busy", u),         32'(bsy), 32'(m_cnt[u] != 0));
    chk($sformatf("u%0d.turn_done", u),    32'(td),  32'(m_td[u]));
    chk($sformatf("u%0d.invalid_roll", u), 32'(inv), 32'(m_inv[u]));
    chk($sformatf("u%0d.winner_valid", u), 32'(wv),  32'(m_win[u]));
    chk($sformatf("u%0d.winner_id", u),    32'(wid), 32'(m_wid[u]));
  endtask

  // Cycle-by-cycle comparison, away from the active edge
  always @(negedge clk) begin
    cmp(0, if0.positions, if0.cur_player, if0.dice_latched, if0.sq_query, if0.busy,
        if0.turn_done, if0.invalid_roll, if0.winner_valid, if0.winner_id);
    cmp(1, if1.positions, if1.cur_player, if1.dice_latched, if1.sq_query, if1.busy,
        if1.turn_done, if1.invalid_roll, if1.winner_valid, if1.winner_id);
    cmp(2, if2.positions, if2.cur_player, if2.dice_latched, if2.sq_query, if2.busy,
        if2.turn_done, if2.invalid_roll, if2.winner_valid, if2.winner_id);
  end

  // ---------------- stimulus ----------------
  task automatic do_reset();
    @(negedge clk); #2 rst = 1'b1;
    @(negedge clk); #2 rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 128; i++) rom_tab[i] = 7'd0;
  endtask

  // Rising edge on roll_req, held for 'hold' extra clocks, then released
  task automatic press(input int d, input int hold);
    @(negedge clk); roll_r = 1'b1; dice_r = 4'(d);
    @(negedge clk); inv_seen = if0.invalid_roll;
    repeat (hold) @(negedge clk);
    roll_r = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  logic [27:0] p;

  initial begin
    rst = 1'b1; roll_r = 1'b0; dice_r = 4'd0; inv_seen = 1'b0;
    clear_rom();
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("reset.positions",    32'(if0.positions), 32'h0204081);
    chk("reset.cur_player",   32'(if0.cur_player), 0);
    chk("reset.busy",         32'(if0.busy), 0);
    chk("reset.winner_valid", 32'(if0.winner_valid), 0);

    // Plain move, empty ROM
    press(3, 0);
    p = if0.positions;
    chk("first.pos0", 32'(p[6:0]), 4);
    chk("first.cur",  32'(if0.cur_player), 1);
    chk("first.sq",   32'(if0.sq_query), 4);
    chk("first.dl",   32'(if0.dice_latched), 3);

    // Ladder, snake, out-of-range destination, six repeat, three-player wrap
    clear_rom();
    rom_tab[4] = 7'd14; rom_tab[17] = 7'd7; rom_tab[20] = 7'd120;
    do_reset();
    press(3, 0); press(5, 0); press(2, 0);
    p = if2.positions;
    chk("wrap.u2.cur",  32'(if2.cur_player), 0);
    chk("wrap.u2.pos2", 32'(p[20:14]), 3);
    press(6, 0);
    chk("six.cur", 32'(if0.cur_player), 1);
    press(5, 0);
    p = if0.positions;
    chk("ladder.pos0", 32'(p[6:0]), 16);
    chk("snake.pos1",  32'(p[13:7]), 7);
    chk("snake.cur",   32'(if0.cur_player), 0);
    p = if2.positions;
    chk("badrom.u2.pos0", 32'(p[6:0]), 25);

    // Invalid dice, held key, edge while busy
    press(0, 0);
    chk("inv.dice0", 32'(inv_seen), 1);
    press(7, 0);
    chk("inv.dice7", 32'(inv_seen), 1);
    press(2, 20);
    p = if0.positions;
    chk("held.pos0", 32'(p[6:0]), 18);
    chk("held.cur",  32'(if0.cur_player), 1);
    @(negedge clk); roll_r = 1'b1; dice_r = 4'd2;
    @(negedge clk); roll_r = 1'b0;
    @(negedge clk); roll_r = 1'b1; dice_r = 4'd5;
    @(negedge clk); roll_r = 1'b0;
    repeat (4) @(negedge clk);
    p = if0.positions;
    chk("busyedge.pos1", 32'(p[13:7]), 9);
    chk("busyedge.dl",   32'(if0.dice_latched), 2);

    // Overshoot: discard (u0) versus clamp-and-win (u1)
    clear_rom();
    rom_tab[5] = 7'd98;
    do_reset();
    press(4, 0); press(1, 0); press(4, 0);
    p = if0.positions;
    chk("exact.pos0",  32'(p[6:0]), 98);
    chk("exact.cur",   32'(if0.cur_player), 1);
    p = if1.positions;
    chk("clamp.pos0",  32'(p[6:0]), 100);
    chk("clamp.wv",    32'(if1.winner_valid), 1);
    chk("clamp.wid",   32'(if1.winner_id), 0);
    press(3, 0);
    p = if1.positions;
    chk("win.frozen.pos0", 32'(p[6:0]), 100);
    chk("win.frozen.dl",   32'(if1.dice_latched), 4);
    chk("win.frozen.busy", 32'(if1.busy), 0);

    // Reset in the middle of LOOKUP
    clear_rom();
    do_reset();
    @(negedge clk); roll_r = 1'b1; dice_r = 4'd3;
    @(negedge clk); roll_r = 1'b0;
    @(negedge clk);
    chk("midturn.sq",   32'(if0.sq_query), 4);
    chk("midturn.busy", 32'(if0.busy), 1);
    #2 rst = 1'b1;
    #1;
    chk("midrst.positions", 32'(if0.positions), 32'h0204081);
    chk("midrst.busy",      32'(if0.busy), 0);
    chk("midrst.sq",        32'(if0.sq_query), 0);
    @(negedge clk); #2 rst = 1'b0;
    repeat (6) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
